// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
// Contents: fetch FSM state encoding, next-PC select (PCS) codes,
// branch-sense (BS) codes and the reset instruction (NOP).
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    localparam logic [1:0] PCS_BRANCH = 2'b00;
    localparam logic [1:0] PCS_JUMP   = 2'b01;
    localparam logic [1:0] PCS_SEQ    = 2'b10;

    localparam logic BS_BGE = 1'b0;
    localparam logic BS_BNE = 1'b1;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection.
// Ports:
//   pc, pcs, bs, zero, neg, alu_res, imm : current PC and control/ALU inputs
//   next_pc  : selected next PC (branch / jump / sequential)
//   pc_plus4 : PC + 4 (modulo 2^XLEN)
//   misalign : next_pc[1] set, target not word aligned
module next_pc_calc
    import fetch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [1:0]      pcs,
    input  logic            bs,
    input  logic            zero,
    input  logic            neg,
    input  logic [XLEN-1:0] alu_res,
    input  logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] next_pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            misalign
);

    logic taken;

    always_comb begin
        pc_plus4 = pc + XLEN'(4);
        // BNE branches on a non-zero difference, BGE on a non-negative one
        taken    = (bs == BS_BNE) ? !zero : !neg;
        next_pc  = pc_plus4;
        case (pcs)
            PCS_JUMP:   next_pc = alu_res & ~XLEN'(1);
            PCS_BRANCH: next_pc = taken ? (pc + imm) : pc_plus4;
            default:    next_pc = pc_plus4;
        endcase
        misalign = next_pc[1];
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Multi-cycle instruction fetch stage: FETCH -> WAIT -> EXEC per instruction.
// Ports:
//   CLK, RST_N               : clock, async active-low reset
//   PCS, BS, ZERO, NEG       : next-PC select and branch condition inputs
//   ALU_RES, IMM             : jump target and branch offset
//   STALL                    : hold EXEC
//   IMEM_RVALID, IMEM_RDATA  : instruction memory response
//   IMEM_REQ, IMEM_ADDR      : instruction memory request
//   INSTR, OP_CODE, FUNCT_3, FUNCT_7 : latched instruction and fields
//   PC, PC_PLUS4             : current PC and PC + 4
//   INSTR_VALID              : EXEC window
//   INSTRET                  : retired-instruction count
//   ERR                      : sticky misalign / fetch timeout
//
// state | meaning
// FETCH | issue one-cycle read request at PC
// WAIT  | wait for read data, count cycles toward timeout
// EXEC  | instruction presented; commit next PC unless stalled
// HALT  | error, absorbing until reset
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter int               TIMEOUT  = 255
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [1:0]      PCS,
    input  logic            BS,
    input  logic            ZERO,
    input  logic            NEG,
    input  logic [XLEN-1:0] ALU_RES,
    input  logic [XLEN-1:0] IMM,
    input  logic            STALL,
    input  logic            IMEM_RVALID,
    input  logic [31:0]     IMEM_RDATA,
    output logic            IMEM_REQ,
    output logic [XLEN-1:0] IMEM_ADDR,
    output logic [31:0]     INSTR,
    output logic [6:0]      OP_CODE,
    output logic [2:0]      FUNCT_3,
    output logic [6:0]      FUNCT_7,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PC_PLUS4,
    output logic            INSTR_VALID,
    output logic [31:0]     INSTRET,
    output logic            ERR
);

    // The counter hits TIMEOUT on the edge that would increment from this value
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [31:0]     instret_q, instret_d;
    logic            err_q, err_d;
    logic [7:0]      wait_cnt_q, wait_cnt_d;
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] pc_plus4;
    logic            misalign;

    next_pc_calc #(.XLEN(XLEN)) u_next_pc (
        .pc       (pc_q),
        .pcs      (PCS),
        .bs       (BS),
        .zero     (ZERO),
        .neg      (NEG),
        .alu_res  (ALU_RES),
        .imm      (IMM),
        .next_pc  (next_pc),
        .pc_plus4 (pc_plus4),
        .misalign (misalign)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            instret_q  <= '0;
            err_q      <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instret_q  <= instret_d;
            err_q      <= err_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instret_d  = instret_q;
        err_d      = err_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            FETCH: begin
                state_d    = WAIT;
                wait_cnt_d = '0;
            end
            WAIT: begin
                if (IMEM_RVALID) begin
                    instr_d    = IMEM_RDATA;
                    state_d    = EXEC;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    err_d      = 1'b1;
                    state_d    = HALT;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            EXEC: begin
                if (!STALL) begin
                    if (misalign) begin
                        err_d   = 1'b1;
                        state_d = HALT;
                    end else begin
                        pc_d      = next_pc;
                        instret_d = instret_q + 32'd1;
                        state_d   = FETCH;
                    end
                end
            end
            default: state_d = HALT;
        endcase
    end

    // Request is gated by RST_N so it drops immediately when reset asserts
    assign IMEM_REQ    = (state_q == FETCH) && RST_N;
    assign INSTR_VALID = (state_q == EXEC);
    assign IMEM_ADDR   = pc_q;
    assign PC          = pc_q;
    assign PC_PLUS4    = pc_plus4;
    assign INSTR       = instr_q;
    assign OP_CODE     = instr_q[6:0];
    assign FUNCT_3     = instr_q[14:12];
    assign FUNCT_7     = instr_q[31:25];
    assign INSTRET     = instret_q;
    assign ERR         = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [1:0]  PCS = 2'b10;
    logic        BS = 1'b0, ZERO = 1'b0, NEG = 1'b0, STALL = 1'b0;
    logic [31:0] ALU_RES = '0, IMM = '0;
    logic        IMEM_RVALID = 1'b0;
    logic [31:0] IMEM_RDATA = '0;
    logic        IMEM_REQ, INSTR_VALID, ERR;
    logic [31:0] IMEM_ADDR, INSTR, PC, PC_PLUS4, INSTRET;
    logic [6:0]  OP_CODE, FUNCT_7;
    logic [2:0]  FUNCT_3;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    instr_fetch_unit dut (
        .CLK(CLK), .RST_N(RST_N), .PCS(PCS), .BS(BS), .ZERO(ZERO), .NEG(NEG),
        .ALU_RES(ALU_RES), .IMM(IMM), .STALL(STALL),
        .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA),
        .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .INSTR(INSTR),
        .OP_CODE(OP_CODE), .FUNCT_3(FUNCT_3), .FUNCT_7(FUNCT_7),
        .PC(PC), .PC_PLUS4(PC_PLUS4), .INSTR_VALID(INSTR_VALID),
        .INSTRET(INSTRET), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Leaves the bench just after a negedge with the DUT in FETCH.
    task automatic do_reset();
        @(negedge CLK);
        RST_N = 1'b0;
        #1;
        chk("rst_req", 32'(IMEM_REQ), 0);
        chk("rst_pc", PC, 32'h0);
        chk("rst_pc4", PC_PLUS4, 32'h4);
        chk("rst_instr", INSTR, NOP);
        chk("rst_op", 32'(OP_CODE), 32'h13);
        chk("rst_valid", 32'(INSTR_VALID), 0);
        chk("rst_err", 32'(ERR), 0);
        chk("rst_instret", INSTRET, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
    endtask

    // Runs one instruction from FETCH through the committing EXEC edge.
    task automatic do_instr(input logic [31:0] word, input int lat, input int stalls,
                            input logic [1:0] pcs, input logic bs, input logic zero,
                            input logic neg, input logic [31:0] alu, input logic [31:0] imm,
                            input logic [31:0] exp_pc);
        chk("fetch_req", 32'(IMEM_REQ), 1);
        chk("fetch_addr", IMEM_ADDR, exp_pc);
        @(negedge CLK);
        chk("wait_req", 32'(IMEM_REQ), 0);
        repeat (lat - 1) @(negedge CLK);
        chk("wait_valid", 32'(INSTR_VALID), 0);
        IMEM_RVALID = 1'b1;
        IMEM_RDATA  = word;
        @(negedge CLK);
        IMEM_RVALID = 1'b0;
        IMEM_RDATA  = 32'hDEAD_BEEF;
        chk("instr", INSTR, word);
        chk("op_code", 32'(OP_CODE), 32'(word[6:0]));
        chk("funct3", 32'(FUNCT_3), 32'(word[14:12]));
        chk("funct7", 32'(FUNCT_7), 32'(word[31:25]));
        chk("pc_plus4", PC_PLUS4, exp_pc + 32'd4);
        PCS = pcs; BS = bs; ZERO = zero; NEG = neg; ALU_RES = alu; IMM = imm;
        for (int s = 0; s <= stalls; s++) begin
            chk("exec_valid", 32'(INSTR_VALID), 1);
            chk("exec_pc", PC, exp_pc);
            STALL = (s < stalls);
            @(negedge CLK);
        end
        STALL = 1'b0;
        PCS = 2'b10; ALU_RES = 32'h0; IMM = 32'h0;
    endtask

    typedef struct {
        logic [31:0] start_pc;
        logic [1:0]  pcs;
        logic        bs, zero, neg;
        logic [31:0] alu, imm;
        logic [31:0] exp_pc;
        logic        exp_err;
    } vec_t;

    vec_t vecs[10];

    initial begin
        //           start_pc      pcs    bs    z     n     alu           imm           exp_pc        err
        vecs[0] = '{32'h10,       2'b00, 1'b1, 1'b0, 1'b0, 32'h0,        32'hFFFF_FFF8, 32'h08,       1'b0};
        vecs[1] = '{32'h10,       2'b00, 1'b1, 1'b1, 1'b0, 32'h0,        32'hFFFF_FFF8, 32'h14,       1'b0};
        vecs[2] = '{32'h40,       2'b00, 1'b0, 1'b0, 1'b0, 32'h0,        32'h20,        32'h60,       1'b0};
        vecs[3] = '{32'h40,       2'b00, 1'b0, 1'b0, 1'b1, 32'h0,        32'h20,        32'h44,       1'b0};
        vecs[4] = '{32'h20,       2'b01, 1'b0, 1'b0, 1'b0, 32'h101,      32'h0,         32'h100,      1'b0};
        vecs[5] = '{32'h20,       2'b01, 1'b0, 1'b0, 1'b0, 32'h102,      32'h0,         32'h20,       1'b1};
        vecs[6] = '{32'h30,       2'b11, 1'b1, 1'b0, 1'b0, 32'h200,      32'h40,        32'h34,       1'b0};
        vecs[7] = '{32'hFFFF_FFFC, 2'b10, 1'b0, 1'b0, 1'b0, 32'h0,       32'h0,         32'h0,        1'b0};
        vecs[8] = '{32'h10,       2'b00, 1'b1, 1'b0, 1'b0, 32'h0,        32'h6,         32'h10,       1'b1};
        vecs[9] = '{32'h40,       2'b00, 1'b0, 1'b1, 1'b0, 32'h0,        32'h20,        32'h60,       1'b0};

        // Back-to-back NOPs, one cycle of memory latency
        do_reset();
        for (int cyc = 0; cyc < 9; cyc++) begin
            chk("seq_req", 32'(IMEM_REQ), 32'((cyc % 3) == 0));
            chk("seq_valid", 32'(INSTR_VALID), 32'((cyc % 3) == 2));
            if ((cyc % 3) == 0) chk("seq_addr", IMEM_ADDR, 32'(4 * (cyc / 3)));
            IMEM_RVALID = ((cyc % 3) == 1);
            IMEM_RDATA  = NOP;
            @(negedge CLK);
        end
        IMEM_RVALID = 1'b0;
        chk("seq_instret", INSTRET, 32'd3);
        chk("seq_next_addr", IMEM_ADDR, 32'hC);

        // Next-PC selection vectors; each starts from a jump to start_pc
        for (int i = 0; i < 10; i++) begin
            do_reset();
            do_instr(32'h0000_006F, 1, 0, 2'b01, 1'b0, 1'b0, 1'b0, vecs[i].start_pc, 32'h0, 32'h0);
            chk("vec_setup_pc", PC, vecs[i].start_pc);
            do_instr(32'hFE20_9CE3 ^ 32'(i << 12), 1 + (i % 2), 0, vecs[i].pcs, vecs[i].bs,
                     vecs[i].zero, vecs[i].neg, vecs[i].alu, vecs[i].imm, vecs[i].start_pc);
            chk("vec_err", 32'(ERR), 32'(vecs[i].exp_err));
            chk("vec_pc", PC, vecs[i].exp_pc);
            if (vecs[i].exp_err) begin
                chk("vec_halt_instret", INSTRET, 32'd1);
                repeat (2) @(negedge CLK);
                chk("vec_halt_req", 32'(IMEM_REQ), 0);
                chk("vec_halt_valid", 32'(INSTR_VALID), 0);
                chk("vec_halt_pc", PC, vecs[i].start_pc);
            end else begin
                chk("vec_instret", INSTRET, 32'd2);
                chk("vec_fetch_req", 32'(IMEM_REQ), 1);
                chk("vec_fetch_addr", IMEM_ADDR, vecs[i].exp_pc);
            end
        end

        // Four stall cycles: five EXEC cycles, one PC update
        do_reset();
        do_instr(32'h00A0_0093, 2, 4, 2'b10, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        chk("stall_pc", PC, 32'h4);
        chk("stall_instret", INSTRET, 32'd1);
        chk("stall_valid_after", 32'(INSTR_VALID), 0);
        chk("stall_fetch_addr", IMEM_ADDR, 32'h4);

        // Fetch timeout: 254 empty WAIT cycles still fine, the 255th errors
        do_reset();
        IMEM_RVALID = 1'b0;
        @(negedge CLK);
        repeat (254) @(negedge CLK);
        chk("to_err_before", 32'(ERR), 0);
        chk("to_still_wait_req", 32'(IMEM_REQ), 0);
        @(negedge CLK);
        chk("to_err", 32'(ERR), 1);
        IMEM_RVALID = 1'b1;
        IMEM_RDATA  = 32'h1234_5678;
        repeat (3) @(negedge CLK);
        chk("to_halt_valid", 32'(INSTR_VALID), 0);
        chk("to_halt_req", 32'(IMEM_REQ), 0);
        chk("to_halt_instr", INSTR, NOP);
        chk("to_halt_err", 32'(ERR), 1);
        IMEM_RVALID = 1'b0;

        // Reset pulse mid-WAIT; a late response is dropped
        do_reset();
        do_instr(32'h0000_006F, 1, 0, 2'b01, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0);
        chk("mid_pc", PC, 32'h40);
        @(negedge CLK);
        repeat (3) @(negedge CLK);
        #2;
        RST_N = 1'b0;
        IMEM_RVALID = 1'b1;
        IMEM_RDATA  = 32'hBAD0_0BAD;
        #1;
        chk("mid_rst_pc", PC, 32'h0);
        chk("mid_rst_err", 32'(ERR), 0);
        chk("mid_rst_req", 32'(IMEM_REQ), 0);
        chk("mid_rst_instret", INSTRET, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        chk("mid_fetch_req", 32'(IMEM_REQ), 1);
        chk("mid_fetch_addr", IMEM_ADDR, 32'h0);
        @(negedge CLK);
        chk("mid_late_instr", INSTR, NOP);
        chk("mid_late_valid", 32'(INSTR_VALID), 0);
        IMEM_RVALID = 1'b0;
        @(negedge CLK);
        chk("mid_wait_valid", 32'(INSTR_VALID), 0);
        chk("mid_wait_instr", INSTR, NOP);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Multi-cycle instruction fetch stage directly upstream of the control unit. It holds the PC, requests each instruction from instruction memory over a valid-based read port, presents the decoded fields (OP_CODE, FUNCT_3, FUNCT_7) to the control unit for one execute window, and then commits the next PC. The control unit drives PCS/BS back in; the ALU flags and result, and the immediate, close the loop.

## Interface
- XLEN, 32: datapath/PC width
- RESET_PC, 32'h0000_0000: PC after reset
- TIMEOUT, 255: max WAIT cycles before error; 8-bit counter
- CLK  in  1  clock, rising edge
- RST_N  in  1  reset; one clock; reset is asynchronous and active-low
- PCS  in  2  next-PC select from control unit: 00 branch, 01 jump, 10 sequential, 11 treated as 10
- BS  in  1  branch sense: 1 = BNE, 0 = BGE
- ZERO  in  1  ALU result == 0
- NEG  in  1  ALU signed result < 0
- ALU_RES  in  XLEN  ALU result (jump target for JAL/JALR)
- IMM  in  XLEN  sign-extended immediate (branch offset)
- STALL  in  1  hold EXEC, e.g. data memory busy
- IMEM_RVALID  in  1  instruction read data valid
- IMEM_RDATA  in  32  instruction word
- IMEM_REQ  out  1  one-cycle read request
- IMEM_ADDR  out  XLEN  read address = PC
- INSTR  out  32  latched instruction
- OP_CODE  out  7  INSTR[6:0]
- FUNCT_3  out  3  INSTR[14:12]
- FUNCT_7  out  7  INSTR[31:25]
- PC  out  XLEN  current PC
- PC_PLUS4  out  XLEN  PC + 4, write-back source for DWS=10
- INSTR_VALID  out  1  high in EXEC; downstream writes permitted only then
- INSTRET  out  32  retired-instruction count
- ERR  out  1  sticky: misaligned target or fetch timeout

## Operation
- States: FETCH, WAIT, EXEC, HALT.
- FETCH: IMEM_REQ=1, IMEM_ADDR=PC; go to WAIT next cycle unconditionally.
- WAIT: IMEM_REQ=0. On IMEM_RVALID, latch IMEM_RDATA into INSTR and go to EXEC. Otherwise increment the wait counter. Counter reaching TIMEOUT sets ERR and goes to HALT. The counter clears on leaving WAIT.
- EXEC: INSTR_VALID=1. If STALL, remain in EXEC with PC unchanged. Else PC <= next_pc, INSTRET += 1, go to FETCH.
- next_pc:
  - PCS=10/11: PC+4.
  - PCS=01: ALU_RES with bit0 cleared.
  - PCS=00: PC+IMM if taken, else PC+4. Taken = BS ? !ZERO : !NEG.
- Misalign: if the selected next_pc[1] is 1 in a non-stalled EXEC, set ERR, leave PC unchanged and INSTRET unchanged, go to HALT.
- HALT: absorbing until reset; INSTR_VALID=0, IMEM_REQ=0.
- IMEM_RVALID outside WAIT is ignored.
- All arithmetic is modulo 2^XLEN, so PC wraps from 0xFFFF_FFFC to 0. INSTRET wraps modulo 2^32.

## Timing
- Reset values: state FETCH, PC=RESET_PC, INSTR=32'h0000_0013 (NOP), INSTR_VALID=0, IMEM_REQ=0 while RST_N low, ERR=0, INSTRET=0, wait counter 0. PC_PLUS4 and fields follow PC/INSTR.
- IMEM_REQ and INSTR_VALID decode combinationally from registered state. PC, INSTR, ERR and INSTRET are registers.
- Minimum 3 cycles per instruction: FETCH, WAIT (RVALID on first WAIT cycle), EXEC. Each extra memory-latency cycle and each STALL cycle adds one.
- Control inputs (PCS, BS, ZERO, NEG, ALU_RES, IMM) are sampled only on the EXEC edge that commits.
- RST_N asserted mid-operation (any state) immediately returns to reset values. An in-flight memory response is dropped.

## Structure
- Shared package fetch_pkg:
  - state enum (FETCH/WAIT/EXEC/HALT)
  - PCS encodings (PCS_BRANCH=00, PCS_JUMP=01, PCS_SEQ=10)
  - NOP_INSTR=32'h0000_0013
  - BS encodings
- Sub-module next_pc_calc: combinational next-PC, branch-taken decision and misalign flag. The top holds the FSM, registers and counters.

## Test plan
- Reset release with RESET_PC=0 and memory returning 0x00000013 after 1 cycle -> IMEM_ADDR 0,4,8; INSTR_VALID every 3rd cycle; INSTRET=3 after 9 cycles.
- BNE with ZERO=0, IMM=-8, PC=0x10 -> next fetch address 0x08. Repeat with ZERO=1 -> 0x14.
- BGE with NEG=0, IMM=0x20, PC=0x40 -> 0x60. With NEG=1 -> 0x44.
- JALR with PCS=01, ALU_RES=0x101 -> PC=0x100, PC_PLUS4 at the jump shows old PC+4. ALU_RES=0x102 -> ERR=1, HALT, PC held.
- STALL high 4 cycles in EXEC -> INSTR_VALID held 5 cycles, a single PC update, INSTRET +1.
- No IMEM_RVALID for 255 WAIT cycles -> ERR=1, HALT. RST_N pulse mid-WAIT -> PC=RESET_PC, ERR=0, and a late RVALID is ignored.
